// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl -- MIPS R2000 decode-stage interlock controller.
//
// Compares the register operands of the instruction in ID against the
// destinations of the instructions in EX and MEM, and sequences the
// multi-cycle HI/LO multiply/divide unit. Produces the PC / IF-ID enables,
// the ID/EX bubble request and the mult/div start pulse, and keeps a
// saturating count of stalled cycles.
//
// Build option:
//   HAZARD_FWD_EN  defined   -> EX/MEM forwarding exists, only load-use stalls
//                  undefined -> no forwarding, any RAW on EX or MEM stalls
//
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   id_rs, id_rt                   source fields of the ID instruction
//   id_uses_rs, id_uses_rt         ID instruction reads rs / rt
//   id_is_muldiv, id_is_div        ID holds MULT/MULTU/DIV/DIVU (div = 1)
//   id_reads_hilo                  ID holds MFHI/MFLO
//   ex_mem_read, ex_reg_write      EX holds a load / writes the register file
//   ex_wreg                        EX destination register
//   mem_reg_write, mem_wreg        MEM writes the register file / destination
//   pc_en, ifid_en                 front-end enables (low while stalled)
//   idex_bubble                    load a NOP into ID/EX this cycle
//   md_start                       one-cycle start pulse to the mult/div unit
//   md_busy                        mult/div unit in progress
//   stall_cnt                      saturating count of stalled cycles
// -----------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int MULT_CYCLES = 12,
  parameter int DIV_CYCLES  = 35,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_is_muldiv,
  input  logic             id_is_div,
  input  logic             id_reads_hilo,
  input  logic             ex_mem_read,
  input  logic             ex_reg_write,
  input  logic [4:0]       ex_wreg,
  input  logic             mem_reg_write,
  input  logic [4:0]       mem_wreg,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_bubble,
  output logic             md_start,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_cnt
);

  // Down-counter must hold the largest preload value, max(cycles) - 1.
  localparam int MAX_CYC = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES - 1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_e;

  md_state_e        state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic match_ex, match_mem;
  logic load_use, raw_ex, raw_mem;
  logic hazard, hilo_wait, stall;

  // Operand match against a producer; $0 is never a real destination.
  assign match_ex  = (ex_wreg != 5'd0) &&
                     ((id_uses_rs && (id_rs == ex_wreg)) ||
                      (id_uses_rt && (id_rt == ex_wreg)));
  assign match_mem = (mem_wreg != 5'd0) &&
                     ((id_uses_rs && (id_rs == mem_wreg)) ||
                      (id_uses_rt && (id_rt == mem_wreg)));

  assign load_use = ex_mem_read   && match_ex;
  assign raw_ex   = ex_reg_write  && match_ex;
  assign raw_mem  = mem_reg_write && match_mem;

`ifdef HAZARD_FWD_EN
  // Forwarding covers ALU results; only a load's data arrives too late.
  assign hazard = load_use;
`else
  assign hazard = load_use | raw_ex | raw_mem;
`endif

  // A second mult/div waits for the unit rather than restarting it.
  assign hilo_wait = md_busy && (id_reads_hilo || id_is_muldiv);
  assign stall     = hazard || hilo_wait;

  assign pc_en       = ~stall;
  assign ifid_en     = ~stall;
  assign idex_bubble = stall;
  assign md_start    = id_is_muldiv && !stall;

  // Decoded from the async-reset state, so reset drops it without a clock.
  assign md_busy   = (state_q == BUSY);
  assign stall_cnt = stall_cnt_q;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (md_start) begin
          cnt_d   = id_is_div ? DIV_LOAD : MULT_LOAD;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Saturate at all-ones rather than wrap.
  assign stall_cnt_d = (stall && (stall_cnt_q != '1)) ? stall_cnt_q + 1'b1
                                                      : stall_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl -- self-checking bench for hazard_ctrl.
//
// The reference model tracks the mult/div unit as "cycles of busy remaining"
// and the stall counter as a clamped integer, and evaluates the hazard rules
// directly from the register fields. Directed scenarios are followed by a
// randomized run. The DUT is built with CNT_W=4 so saturation is reachable.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

  localparam int MULT_CYCLES = 12;
  localparam int DIV_CYCLES  = 35;
  localparam int CNT_W       = 4;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [4:0]       id_rs, id_rt, ex_wreg, mem_wreg;
  logic             id_uses_rs, id_uses_rt, id_is_muldiv, id_is_div;
  logic             id_reads_hilo, ex_mem_read, ex_reg_write, mem_reg_write;
  logic             pc_en, ifid_en, idex_bubble, md_start, md_busy;
  logic [CNT_W-1:0] stall_cnt;

  hazard_ctrl #(
    .MULT_CYCLES(MULT_CYCLES),
    .DIV_CYCLES (DIV_CYCLES),
    .CNT_W      (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rs   (id_uses_rs),
    .id_uses_rt   (id_uses_rt),
    .id_is_muldiv (id_is_muldiv),
    .id_is_div    (id_is_div),
    .id_reads_hilo(id_reads_hilo),
    .ex_mem_read  (ex_mem_read),
    .ex_reg_write (ex_reg_write),
    .ex_wreg      (ex_wreg),
    .mem_reg_write(mem_reg_write),
    .mem_wreg     (mem_wreg),
    .pc_en        (pc_en),
    .ifid_en      (ifid_en),
    .idex_bubble  (idex_bubble),
    .md_start     (md_start),
    .md_busy      (md_busy),
    .stall_cnt    (stall_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state.
  int m_busy_left = 0;
  int m_stall_cnt = 0;
  bit last_stall, last_start;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
    id_is_muldiv = 0; id_is_div = 0; id_reads_hilo = 0;
    ex_mem_read = 0; ex_reg_write = 0; ex_wreg = 0;
    mem_reg_write = 0; mem_wreg = 0;
  endtask

  function automatic bit reads_reg(input int r);
    if (r == 0) return 0;
    return (id_uses_rs && int'(id_rs) == r) || (id_uses_rt && int'(id_rt) == r);
  endfunction

  function automatic bit model_stall();
    bit lu, rx, rm;
    lu = ex_mem_read   && reads_reg(int'(ex_wreg));
    rx = ex_reg_write  && reads_reg(int'(ex_wreg));
    rm = mem_reg_write && reads_reg(int'(mem_wreg));
`ifdef HAZARD_FWD_EN
    rx = 0;
    rm = 0;
`endif
    return lu || rx || rm ||
           ((m_busy_left > 0) && (id_reads_hilo || id_is_muldiv));
  endfunction

  // One clock cycle: compare every output mid-cycle, then advance the model.
  task automatic cycle();
    @(negedge clk);
    last_stall = model_stall();
    last_start = id_is_muldiv && !last_stall;
    check("pc_en",       32'(pc_en),       32'(!last_stall));
    check("ifid_en",     32'(ifid_en),     32'(!last_stall));
    check("idex_bubble", 32'(idex_bubble), 32'(last_stall));
    check("md_start",    32'(md_start),    32'(last_start));
    check("md_busy",     32'(md_busy),     32'(m_busy_left > 0));
    check("stall_cnt",   32'(stall_cnt),   32'(m_stall_cnt));
    @(posedge clk);
    if (last_stall && m_stall_cnt < CNT_MAX) m_stall_cnt++;
    if (m_busy_left > 0) m_busy_left--;
    if (last_start) m_busy_left = id_is_div ? DIV_CYCLES : MULT_CYCLES;
    #1;
  endtask

  initial begin
    int n;
    clear_inputs();
    rst = 1'b1;
    #12 rst = 1'b0;

    // Reset state with quiet inputs.
    cycle();

    // Load-use on $8: one stalled cycle, then the load moves to MEM.
    ex_mem_read = 1; ex_reg_write = 1; ex_wreg = 8; id_rs = 8; id_uses_rs = 1;
    cycle();
    check("load_use_stall", 32'(last_stall), 32'd1);
    clear_inputs();
    cycle();
    check("load_use_cnt", 32'(stall_cnt), 32'd1);

    // Load into $0 never stalls.
    ex_mem_read = 1; ex_reg_write = 1; ex_wreg = 0; id_rs = 0; id_uses_rs = 1;
    cycle();
    check("load_r0_nostall", 32'(last_stall), 32'd0);
    clear_inputs();

    // ALU RAW on rt against EX, then against MEM.
    ex_reg_write = 1; ex_wreg = 3; id_rt = 3; id_uses_rt = 1;
    cycle();
`ifdef HAZARD_FWD_EN
    check("raw_ex_stall", 32'(last_stall), 32'd0);
`else
    check("raw_ex_stall", 32'(last_stall), 32'd1);
`endif
    ex_reg_write = 0; mem_reg_write = 1; mem_wreg = 3;
    cycle();
    clear_inputs();
    cycle();

    // MULT, then MFHI held in ID: stalls MULT_CYCLES cycles.
    id_is_muldiv = 1;
    cycle();
    check("mult_start", 32'(last_start), 32'd1);
    clear_inputs();
    id_reads_hilo = 1;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (!last_stall) break;
      n++;
    end
    check("mfhi_stall_cycles", 32'(n), 32'(MULT_CYCLES));
    clear_inputs();

    // DIV, then MULT waiting in ID: starts once after DIV_CYCLES stalls.
    id_is_muldiv = 1; id_is_div = 1;
    cycle();
    check("div_start", 32'(last_start), 32'd1);
    id_is_div = 0;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      cycle();
      if (last_start) break;
      n++;
    end
    check("mult_after_div_stalls", 32'(n), 32'(DIV_CYCLES));
    clear_inputs();
    for (int i = 0; i < MULT_CYCLES + 1; i++) cycle();

    // MULT suppressed while a load-use stall is pending.
    id_is_muldiv = 1; ex_mem_read = 1; ex_wreg = 5; id_rs = 5; id_uses_rs = 1;
    cycle();
    check("start_suppressed", 32'(last_start), 32'd0);
    ex_mem_read = 0;
    cycle();
    check("start_after_stall", 32'(last_start), 32'd1);
    clear_inputs();

    // Async reset in the 5th BUSY cycle.
    for (int i = 0; i < 4; i++) cycle();
    @(negedge clk);
    check("busy_before_rst", 32'(md_busy), 32'd1);
    rst = 1'b1;
    #1;
    check("rst_async_busy", 32'(md_busy), 32'd0);
    check("rst_async_cnt",  32'(stall_cnt), 32'd0);
    #1 rst = 1'b0;
    m_busy_left = 0;
    m_stall_cnt = 0;
    @(posedge clk);
    #1;
    id_is_muldiv = 1;
    cycle();
    check("mult_after_rst", 32'(last_start), 32'd1);
    clear_inputs();
    for (int i = 0; i < MULT_CYCLES; i++) cycle();

    // Saturation: 2^CNT_W + 3 consecutive stalled cycles.
    ex_mem_read = 1; ex_wreg = 9; id_rt = 9; id_uses_rt = 1;
    for (int i = 0; i < (1 << CNT_W) + 3; i++) cycle();
    clear_inputs();
    cycle();
    check("stall_cnt_sat", 32'(stall_cnt), 32'(CNT_MAX));

    // Randomized traffic; small register range to provoke matches.
    for (int i = 0; i < 600; i++) begin
      id_rs         = 5'($urandom_range(0, 3));
      id_rt         = 5'($urandom_range(0, 3));
      id_uses_rs    = 1'($urandom_range(0, 1));
      id_uses_rt    = 1'($urandom_range(0, 1));
      id_is_muldiv  = ($urandom_range(0, 15) == 0);
      id_is_div     = 1'($urandom_range(0, 1));
      id_reads_hilo = ($urandom_range(0, 7) == 0);
      ex_mem_read   = ($urandom_range(0, 3) == 0);
      ex_reg_write  = 1'($urandom_range(0, 1));
      ex_wreg       = 5'($urandom_range(0, 3));
      mem_reg_write = 1'($urandom_range(0, 1));
      mem_wreg      = 5'($urandom_range(0, 3));
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline interlock controller for the MIPS R2000 decode stage (ID).
- Inspects the instruction held in ID against the instructions in EX and MEM, and sequences the multi-cycle HI/LO multiply/divide unit.
- Drives the PC/IF-ID enables, the ID/EX bubble insertion and the mult/div start pulse.
- Sits beside `ID`, between the IF/ID and ID/EX pipeline registers.

## Interface
Parameters:
- MULT_CYCLES, 12, busy cycles for MULT/MULTU (≥1)
- DIV_CYCLES, 35, busy cycles for DIV/DIVU (≥1)
- CNT_W, 16, width of the stall performance counter

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-high
- id_rs  in  5  rs field of instruction in ID (inst_in[25:21])
- id_rt  in  5  rt field of instruction in ID (inst_in[20:16])
- id_uses_rs / id_uses_rt  in  1 each  ID instruction reads rs / rt
- id_is_muldiv  in  1  ID holds MULT/MULTU/DIV/DIVU
- id_is_div  in  1  qualifies id_is_muldiv: 1 = divide, 0 = multiply
- id_reads_hilo  in  1  ID holds MFHI/MFLO
- ex_mem_read  in  1  EX holds a load
- ex_reg_write  in  1  EX instruction writes the register file
- ex_wreg  in  5  EX destination register
- mem_reg_write  in  1  MEM instruction writes the register file
- mem_wreg  in  5  MEM destination register
- pc_en  out  1  PC update enable
- ifid_en  out  1  IF/ID register load enable
- idex_bubble  out  1  load NOP into ID/EX this cycle
- md_start  out  1  one-cycle start pulse to mult/div unit
- md_busy  out  1  mult/div unit in progress
- stall_cnt  out  CNT_W  saturating count of stalled cycles

## Operation
- RAW hazard terms (each requires the destination register ≠ 0):
  - load_use = ex_mem_read & ex_wreg≠0 & ((id_uses_rs & id_rs==ex_wreg) | (id_uses_rt & id_rt==ex_wreg)).
  - raw_ex = the same match against ex_wreg, qualified by ex_reg_write.
  - raw_mem = the same match against mem_wreg, qualified by mem_reg_write.
- hilo_wait = md_busy & (id_reads_hilo | id_is_muldiv). A second mult/div waits; it is not restarted.
- stall = hazard term (see Configuration) | hilo_wait.
- When stall=1: pc_en=0, ifid_en=0, idex_bubble=1. Otherwise pc_en=ifid_en=1, idex_bubble=0.
- md_start = id_is_muldiv & ~stall. It is combinational and accepted in the cycle it is high.
- FSM states:
  - IDLE: on md_start, load cnt with (id_is_div ? DIV_CYCLES : MULT_CYCLES) − 1 and go to BUSY.
  - BUSY: md_busy=1. If cnt==0, go to IDLE; else cnt−1.
- stall_cnt increments at each clock edge where stall=1. It saturates at all-ones and never wraps.
- Register 0 never causes a hazard, even when a load targets $0.

## Timing
- Reset values:
  - Registered: state=IDLE, cnt=0, stall_cnt=0, md_busy=0.
  - Combinational outputs follow from inputs: with no hazard inputs active, pc_en=ifid_en=1, idex_bubble=0, md_start=0.
- Async reset mid-BUSY aborts the sequence immediately. md_busy drops without waiting for a clock edge.
- Stall and bubble outputs are combinational, with zero-cycle latency.
- Load-use stalls exactly 1 cycle, because the load advances to MEM.
- A multiply started at edge T gives md_busy=1 for cycles T+1 … T+MULT_CYCLES. An MFHI in ID is released in cycle T+MULT_CYCLES+1.
- Simultaneous mult/div in ID and a RAW stall: md_start is suppressed until the stall clears, and is then issued once.
- A BUSY→IDLE transition and a new mult/div in ID in the same cycle: the new op stalls that cycle (md_busy still 1) and starts the next cycle.

## Configuration
- HAZARD_FWD_EN defined: EX/MEM forwarding exists, so the hazard term = load_use only.
- Undefined: no forwarding, so the hazard term = load_use | raw_ex | raw_mem. Stalls last until the producer leaves MEM (up to 2 cycles).

## Test plan
- Load-use: ex_mem_read=1, ex_wreg=8, id_rs=8, id_uses_rs=1 → one cycle with pc_en=0, ifid_en=0, idex_bubble=1; stall_cnt=1. Same stimulus with ex_wreg=0 → no stall.
- MULT then MFHI, MULT_CYCLES=12:
  - md_start high 1 cycle, then md_busy high 12 cycles.
  - MFHI held in ID stalls 12 cycles and proceeds in the 13th.
- DIV followed by MULT: the MULT stalls 35 cycles, then md_start pulses once with a 12-cycle BUSY.
- Without HAZARD_FWD_EN: ex_reg_write=1, ex_wreg=3, id_rt=3, id_uses_rt=1 → stall asserted. With HAZARD_FWD_EN, the same stimulus → no stall.
- rst asserted asynchronously in the 5th BUSY cycle → md_busy=0 and stall_cnt=0 before the next edge. After release, a new MULT starts normally.
- Force 2^CNT_W+3 stall cycles (CNT_W=4 build) → stall_cnt holds at 15.
